// File: rtl/uart_pkg.sv
// Shared UART definitions: receive-sequencer state encoding, default word size and
// the bit-rate timing constants used by the bit-rate counter, RX and TX paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam int DEFAULT_DATA_BITS = 8;
    localparam int BPS_PERIOD        = 100;
    localparam int BPS_MID           = 49;

endpackage

// File: rtl/rx_sync_edge.sv
// Multi-flop synchroniser for an asynchronous idle-high line plus falling-edge detect.
// Flops reset to 1 so a line held low through reset is not seen as an edge.
module rx_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic serial,
    output logic synced,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            sync_q <= '1;
            dly_q  <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], serial};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];
    assign fall   = dly_q & ~synced;

endmodule

// File: rtl/rx_control_module.sv
// UART receive sequencer: start detect, mid-bit sampling on BPS_CLK, LSB-first assembly,
// stop check and one-cycle done/error strobes. RX_PARITY_EN adds a parity bit before stop.
module rx_control_module
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = DEFAULT_DATA_BITS,
    parameter int SYNC_STAGES = 2
`ifdef RX_PARITY_EN
    ,
    parameter bit PARITY_ODD  = 1'b0
`endif
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 RX_En_Sig,
    input  logic                 RX_Pin_In,
    input  logic                 BPS_CLK,
    output logic                 Count_Sig,
    output logic [DATA_BITS-1:0] RX_Data,
    output logic                 RX_Done_Sig,
    output logic                 RX_Err_Sig
);

    localparam int                 IDX_W    = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(DATA_BITS - 1);

    rx_state_t              state, state_nxt;
    logic [IDX_W-1:0]       bit_idx, bit_idx_nxt;
    logic [DATA_BITS-1:0]   shift_reg, shift_nxt, data_nxt;
    logic                   done_nxt, err_nxt;
    logic                   synced, fall;
    logic                   frame_ok;

    rx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .CLK    (CLK),
        .RSTn   (RSTn),
        .serial (RX_Pin_In),
        .synced (synced),
        .fall   (fall)
    );

`ifdef RX_PARITY_EN
    logic par_bad, par_bad_nxt;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) par_bad <= 1'b0;
        else       par_bad <= par_bad_nxt;
    end

    always_comb begin
        par_bad_nxt = par_bad;
        if (state == PARITY && BPS_CLK)
            par_bad_nxt = (synced != ((^shift_reg) ^ PARITY_ODD));
    end

    assign frame_ok = synced & ~par_bad;
`else
    assign frame_ok = synced;
`endif

    // The counter runs for the whole frame, so its request is simply "not idle".
    assign Count_Sig = (state != IDLE);

    always_comb begin
        state_nxt   = state;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift_reg;
        data_nxt    = RX_Data;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (fall && RX_En_Sig) state_nxt = START;
            end
            START: begin
                if (BPS_CLK) begin
                    bit_idx_nxt = '0;
                    state_nxt   = synced ? IDLE : DATA;
                end
            end
            DATA: begin
                if (BPS_CLK) begin
                    shift_nxt[bit_idx] = synced;
                    bit_idx_nxt        = bit_idx + 1'b1;
                    if (bit_idx == LAST_IDX) begin
                        bit_idx_nxt = '0;
`ifdef RX_PARITY_EN
                        state_nxt   = PARITY;
`else
                        state_nxt   = STOP;
`endif
                    end
                end
            end
`ifdef RX_PARITY_EN
            PARITY: begin
                if (BPS_CLK) state_nxt = STOP;
            end
`endif
            STOP: begin
                if (BPS_CLK) begin
                    state_nxt = IDLE;
                    if (frame_ok) begin
                        data_nxt = shift_reg;
                        done_nxt = 1'b1;
                    end else begin
                        err_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state       <= IDLE;
            bit_idx     <= '0;
            shift_reg   <= '0;
            RX_Data     <= '0;
            RX_Done_Sig <= 1'b0;
            RX_Err_Sig  <= 1'b0;
        end else begin
            state       <= state_nxt;
            bit_idx     <= bit_idx_nxt;
            shift_reg   <= shift_nxt;
            RX_Data     <= data_nxt;
            RX_Done_Sig <= done_nxt;
            RX_Err_Sig  <= err_nxt;
        end
    end

endmodule

// File: tb/tb_rx_control_module.sv
// Bench: DUT paired with a 100-clock bit-rate counter, frame-level expectation queue,
// directed scenarios followed by randomized frames.
module tb_rx_control_module;
    import uart_pkg::*;

    localparam int DW = 8;
`ifdef RX_PARITY_EN
    localparam int FRAME_BITS = DW + 3;
`else
    localparam int FRAME_BITS = DW + 2;
`endif

    logic          CLK       = 1'b0;
    logic          RSTn      = 1'b0;
    logic          RX_En_Sig = 1'b1;
    logic          RX_Pin_In = 1'b1;
    logic          BPS_CLK;
    logic          Count_Sig;
    logic [DW-1:0] RX_Data;
    logic          RX_Done_Sig;
    logic          RX_Err_Sig;

    rx_control_module #(.DATA_BITS(DW), .SYNC_STAGES(2)) dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .RX_En_Sig   (RX_En_Sig),
        .RX_Pin_In   (RX_Pin_In),
        .BPS_CLK     (BPS_CLK),
        .Count_Sig   (Count_Sig),
        .RX_Data     (RX_Data),
        .RX_Done_Sig (RX_Done_Sig),
        .RX_Err_Sig  (RX_Err_Sig)
    );

    always #5 CLK = ~CLK;

    // Bit-rate counter partner: pulses at mid-bit while the receiver requests it.
    int cnt = 0;
    always @(posedge CLK) begin
        if (!Count_Sig || cnt == BPS_PERIOD - 1) cnt <= 0;
        else                                     cnt <= cnt + 1;
    end
    assign BPS_CLK = Count_Sig && (cnt == BPS_MID);

    typedef struct {
        bit           is_err;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          cmp_e;
    logic [DW-1:0] last_good = '0;
    int            checks    = 0;
    int            failures  = 0;
    int            n_done    = 0;
    int            n_err     = 0;
    int            cyc       = 0;
    int            done_cyc[$];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (RSTn) begin
            chk("done_err_excl", 32'(RX_Done_Sig & RX_Err_Sig), 32'd0);
            if (RX_Done_Sig || RX_Err_Sig) begin
                if (RX_Done_Sig) begin
                    n_done++;
                    done_cyc.push_back(cyc);
                end
                if (RX_Err_Sig) n_err++;
                chk("count_low_at_strobe", 32'(Count_Sig), 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    cmp_e = exp_q.pop_front();
                    chk("strobe_kind_err", 32'(RX_Err_Sig), 32'(cmp_e.is_err));
                    if (!cmp_e.is_err) last_good = cmp_e.data;
                end
            end
            chk("rx_data", 32'(RX_Data), 32'(last_good));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        RX_Pin_In = b;
        tick(BPS_PERIOD);
    endtask

    task automatic idle(input int n);
        RX_Pin_In = 1'b1;
        tick(n);
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input bit stop_ok, input bit en,
                              input bit mid_drop);
        exp_t e;
        e.is_err = !stop_ok;
        e.data   = d;
        if (en) exp_q.push_back(e);
        RX_En_Sig = en;
        send_bit(1'b0);
        if (mid_drop) RX_En_Sig = 1'b0;
        for (int i = 0; i < DW; i++) send_bit(d[i]);
`ifdef RX_PARITY_EN
        send_bit(^d);
`endif
        send_bit(stop_ok);
        RX_En_Sig = 1'b1;
    endtask

    initial begin
        int nd0, ne0, rise, fall_c, diff;
        logic [DW-1:0] d;
        bit err, en, mid;

        RSTn = 1'b0;
        tick(5);
        chk("reset_count", 32'(Count_Sig), 32'd0);
        chk("reset_data", 32'(RX_Data), 32'd0);
        chk("reset_done", 32'(RX_Done_Sig), 32'd0);
        chk("reset_err", 32'(RX_Err_Sig), 32'd0);
        RSTn = 1'b1;
        tick(20);

        send_frame(8'h55, 1'b1, 1'b1, 1'b0);
        idle(200);
        chk("lit_55", 32'(RX_Data), 32'h55);
        chk("n_done_after_55", 32'(n_done), 32'd1);
        chk("n_err_after_55", 32'(n_err), 32'd0);

        send_frame(8'hA3, 1'b1, 1'b1, 1'b0);
        chk("lit_A3", 32'(RX_Data), 32'hA3);
        send_frame(8'h0F, 1'b1, 1'b1, 1'b0);
        idle(200);
        chk("lit_0F", 32'(RX_Data), 32'h0F);
        diff = (done_cyc.size() >= 2) ? done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2] : 0;
        chk("b2b_spacing", 32'(diff >= FRAME_BITS*BPS_PERIOD - 5 && diff <= FRAME_BITS*BPS_PERIOD + 5), 32'd1);

        // Short low glitch: the start-bit sample sees high and aborts.
        nd0 = n_done; ne0 = n_err; rise = -1; fall_c = -1;
        RX_Pin_In = 1'b0;
        for (int c = 0; c < 300; c++) begin
            tick(1);
            if (c == 19) RX_Pin_In = 1'b1;
            if (Count_Sig && rise < 0) rise = c;
            if (!Count_Sig && rise >= 0 && fall_c < 0) fall_c = c;
        end
        chk("glitch_rise_seen", 32'(rise >= 0 && rise < 10), 32'd1);
        chk("glitch_count_window", 32'(fall_c >= 0 && (fall_c - rise) >= 45 && (fall_c - rise) <= 55), 32'd1);
        chk("glitch_no_done", 32'(n_done), 32'(nd0));
        chk("glitch_no_err", 32'(n_err), 32'(ne0));

        // Framing error followed by a long break.
        nd0 = n_done; ne0 = n_err;
        send_frame(8'hFF, 1'b0, 1'b1, 1'b0);
        chk("err_keeps_data", 32'(RX_Data), 32'h0F);
        chk("err_count", 32'(n_err - ne0), 32'd1);
        RX_Pin_In = 1'b0;
        tick(2000);
        idle(300);
        chk("break_single_err", 32'(n_err - ne0), 32'd1);
        chk("break_no_done", 32'(n_done), 32'(nd0));

        nd0 = n_done;
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        idle(200);
        chk("disabled_ignored", 32'(n_done), 32'(nd0));

        // Asynchronous reset in the middle of data bit 4.
        d = 8'h3C;
        RX_Pin_In = 1'b0;
        tick(BPS_PERIOD);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        RX_Pin_In = d[4];
        tick(50);
        RSTn = 1'b0;
        #1;
        chk("arst_count", 32'(Count_Sig), 32'd0);
        chk("arst_data", 32'(RX_Data), 32'd0);
        chk("arst_done", 32'(RX_Done_Sig), 32'd0);
        chk("arst_err", 32'(RX_Err_Sig), 32'd0);
        last_good = '0;
        RX_Pin_In = 1'b1;
        tick(3);
        RSTn = 1'b1;
        idle(300);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
        idle(200);
        chk("lit_3C", 32'(RX_Data), 32'h3C);

        for (int f = 0; f < 30; f++) begin
            d   = 8'($urandom);
            en  = ($urandom_range(0, 7) != 0);
            err = en && ($urandom_range(0, 9) == 0);
            mid = en && ($urandom_range(0, 3) == 0);
            send_frame(d, !err, en, mid);
            idle(err ? int'($urandom_range(5, 250)) : int'($urandom_range(0, 250)));
        end

        idle(300);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
